// File: rtl/tluh_atomic_unit.sv
// TL-UH atomic read-modify-write engine: one read, a lane-sized ALU step, one
// byte-masked write-back, and a response that returns the old lane value.
module tluh_atomic_unit #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int SZW = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_opcode_i,
  input  logic [2:0]        req_param_i,
  input  logic [SZW-1:0]    req_size_i,
  input  logic [AW-1:0]     req_addr_i,
  input  logic [DW-1:0]     req_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW/8-1:0]   mem_be_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_data_o,
  output logic              rsp_error_o
);

  localparam int BW = DW / 8;
  localparam int LB = $clog2(BW);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP} state_t;

  state_t          state;
  logic            arith_q;
  logic [2:0]      param_q;
  logic [LB-1:0]   off_q;
  logic [DW-1:0]   mask_q;
  logic [DW-1:0]   opnd_q;
  logic [DW-1:0]   old_q;

  // Request decode: feeds registers only, never an output directly.
  logic            req_legal;
  logic [DW-1:0]   req_mask;
  logic [DW-1:0]   req_opnd;
  logic [BW-1:0]   req_be;
  logic [BW-1:0]   be_base;
  logic [LB+2:0]   req_shamt;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    req_mask = '0;
    be_base  = '0;
    for (int i = 0; i < BW; i++) begin
      if (i < (1 << req_size_i)) begin
        req_mask[i*8 +: 8] = 8'hFF;
        be_base[i]         = 1'b1;
      end
    end
    req_shamt = {req_addr_i[LB-1:0], 3'b000};
    req_be    = be_base << req_addr_i[LB-1:0];
    req_opnd  = (req_data_i >> req_shamt) & req_mask;
    req_legal = ((req_opcode_i == 3'd2 && req_param_i <= 3'd4) ||
                 (req_opcode_i == 3'd3 && req_param_i <= 3'd3)) &&
                ((1 << req_size_i) <= BW) &&
                ((int'(req_addr_i[LB-1:0]) & ((1 << req_size_i) - 1)) == 0);
  end

  // Lane ALU: values are right-justified and sign-extended from the lane's top bit.
  logic [LB+2:0]   shamt;
  logic [DW-1:0]   top_bit;
  logic [DW-1:0]   old_lane, old_sx, opnd_sx;
  logic            old_lt, opnd_lt;
  logic [DW-1:0]   result;
  logic [DW-1:0]   new_aligned, old_aligned;

  always_comb begin
    shamt    = {off_q, 3'b000};
    top_bit  = mask_q ^ (mask_q >> 1);
    old_lane = (mem_rdata_i >> shamt) & mask_q;
    old_sx   = old_lane | (((old_lane & top_bit) != '0) ? ~mask_q : '0);
    opnd_sx  = opnd_q   | (((opnd_q   & top_bit) != '0) ? ~mask_q : '0);
    old_lt   = 1'b0;
    opnd_lt  = 1'b0;
    if (arith_q && (param_q == 3'd2 || param_q == 3'd3)) begin
      old_lt  = old_lane < opnd_q;
      opnd_lt = opnd_q < old_lane;
    end else begin
      old_lt  = $signed(old_sx) < $signed(opnd_sx);
      opnd_lt = $signed(opnd_sx) < $signed(old_sx);
    end
    result = old_lane;
    if (arith_q) begin
      case (param_q)
        3'd0, 3'd2: result = opnd_lt ? opnd_q : old_lane;
        3'd1, 3'd3: result = old_lt  ? opnd_q : old_lane;
        3'd4:       result = old_lane + opnd_q;
        default:    result = old_lane;
      endcase
    end else begin
      case (param_q)
        3'd0:    result = old_lane ^ opnd_q;
        3'd1:    result = old_lane | opnd_q;
        3'd2:    result = old_lane & opnd_q;
        default: result = opnd_q;
      endcase
    end
    new_aligned = (result & mask_q) << shamt;
    old_aligned = old_lane << shamt;
  end

  // NOTE: all outputs are flops, so each transition also loads the next state's outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_error_o <= 1'b0;
      arith_q     <= 1'b0;
      param_q     <= '0;
      off_q       <= '0;
      mask_q      <= '0;
      opnd_q      <= '0;
      old_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            arith_q     <= (req_opcode_i == 3'd2);
            param_q     <= req_param_i;
            off_q       <= req_addr_i[LB-1:0];
            mask_q      <= req_mask;
            opnd_q      <= req_opnd;
            if (req_legal) begin
              state      <= RD;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {req_addr_i[AW-1:LB], {LB{1'b0}}};
              mem_be_o   <= req_be;
            end else begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_error_o <= 1'b1;
              rsp_data_o  <= '0;
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        RD: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RWAIT;
          end
        end
        RWAIT: begin
          // Only reachable a cycle after the grant, so a grant-cycle rvalid is never seen.
          if (mem_rvalid_i) begin
            old_q       <= old_aligned;
            mem_wdata_o <= new_aligned;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            state       <= WR;
          end
        end
        WR: begin
          if (mem_gnt_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            rsp_valid_o <= 1'b1;
            rsp_error_o <= 1'b0;
            rsp_data_o  <= old_q;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_error_o <= 1'b0;
            rsp_data_o  <= '0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tluh_atomic_unit.md
# tluh_atomic_unit

Sequential read-modify-write engine for TL-UH atomic operations. Covers both ArithmeticData (MIN, MAX, MINU, MAXU, ADD) and LogicalData (XOR, OR, AND, SWAP). It sits between the TL-UH slave adapter and a single-port memory or peripheral bus. Each accepted request becomes one read, one ALU evaluation at the requested operand size, one byte-masked write-back and one response carrying the old value. Data width is parametrised, and sub-word operands are lane-extracted from the bus word.

## Interface
- DW, 32: data width in bits; power of two, 32 or 64.
- AW, 32: address width in bits.
- SZW, 2: width of the size field (log2 bytes).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  atomic request valid.
- req_ready_o  out  1  request accepted when high with valid.
- req_opcode_i  in  3  TL-UH opcode: 2 = ArithmeticData, 3 = LogicalData.
- req_param_i  in  3  arithmetic: 0 MIN, 1 MAX, 2 MINU, 3 MAXU, 4 ADD; logical: 0 XOR, 1 OR, 2 AND, 3 SWAP.
- req_size_i  in  SZW  operand size, 2^size bytes.
- req_addr_i  in  AW  byte address.
- req_data_i  in  DW  operand, lane-aligned as on the bus.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  AW  word-aligned address (low log2(DW/8) bits zero).
- mem_be_o  out  DW/8  byte enables.
- mem_wdata_o  out  DW  write data.
- mem_gnt_i  in  1  request granted this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DW  read data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  DW  old memory value, lane-aligned; bytes outside the lane are 0.
- rsp_error_o  out  1  request was illegal; no memory access performed.

## Operation
- FSM states: IDLE, RD, RWAIT, WR, RESP.
- IDLE:
  - req_ready_o=1; on valid&&ready, register opcode, param, size, addr and data.
  - If the request is legal, go to RD; otherwise go to RESP with error.
- Illegal request, any of:
  - opcode not 2 or 3;
  - arithmetic param > 4 or logical param > 3;
  - 2^size > DW/8;
  - addr not aligned to 2^size.
- Lane mask: be = ((1<<2^size)-1) << addr[log2(DW/8)-1:0].
- RD: mem_req_o=1, mem_we_o=0, mem_be_o=be. Hold all outputs until mem_gnt_i, then go to RWAIT.
- RWAIT: on mem_rvalid_i, capture rdata, compute the new value and go to WR. rvalid in the grant cycle is ignored; it is legal earliest one cycle after the grant.
- ALU: operates on the extracted lane values old and opnd at operand width.
  - MIN/MAX: signed compare; MINU/MAXU: unsigned compare. The selected value is written; ties select old.
  - ADD: wraps modulo 2^(8·2^size); carry discarded.
  - XOR/OR/AND: bitwise. SWAP writes opnd.
  - The result is re-aligned to its lane.
- WR: mem_req_o=1, mem_we_o=1, mem_be_o=be, mem_wdata_o=new value in lane, 0 elsewhere. Hold until mem_gnt_i, then go to RESP.
- RESP:
  - rsp_valid_o=1; rsp_data_o = old lane value (0 on error).
  - Hold until rsp_ready_i, then go to IDLE.
- Exactly one operation is outstanding; no new request is accepted before RESP completes.

## Timing
- Reset values: req_ready_o=0 during reset, 1 in the first cycle after reset. All other outputs 0.
- Reset mid-operation: abort immediately to IDLE; any pending memory request is dropped and no response is issued.
- Minimum latency with gnt and rvalid at the earliest legal cycles (accept in cycle 0):
  - RD with gnt in cycle 1;
  - rvalid in cycle 2;
  - WR with gnt in cycle 3;
  - rsp_valid_o in cycle 4.
- Error path: accept in cycle 0, rsp_valid_o in cycle 1.
- Handshake stability: mem_* outputs are registered and stable while mem_req_o=1 and no grant has occurred. rsp_* outputs are stable while rsp_valid_o=1 and rsp_ready_i=0.
- No combinational path from any input to any output except none; all outputs are driven from registers.

## Test plan
- ADD, DW=32, size 2, addr 0x10, mem=0xFFFFFFFF, data=2 -> write 0x00000001 with be=0xF; rsp_data=0xFFFFFFFF.
- MIN signed, size 0, addr 0x3, mem byte3=0x80, data byte3=0x05 -> no change in value (0x80 written back), be=0x8; rsp_data=0x80000000. MINU with the same stimulus -> 0x05 written.
- SWAP, size 1, addr 0x2, mem=0xAABBCCDD, data=0x12340000 -> wdata=0x12340000, be=0xC; rsp_data=0xAABB0000.
- Illegal requests -> rsp_error_o=1 with rsp_data=0, no mem_req_o, response one cycle after accept:
  - opcode 3, param 5;
  - size 2 at addr 0x2 (misaligned).
- Stalls: gnt delayed 3 cycles in RD and WR, rvalid delayed 2 cycles, rsp_ready_i low 4 cycles -> outputs held stable throughout; req_ready_o stays 0 until the response is consumed.
- rst_i asserted in RWAIT -> next cycle is IDLE with all outputs 0; a following XOR request (mem=0xF0F0F0F0, data=0xFF00FF00) writes 0x0FF00FF0.
